// File: rtl/mmio_timer_uart_if.sv
// MEM-stage data bus shared with the data RAM.
//   Address    : byte address from the MEM stage
//   Write_data : store data
//   MemRead    : load strobe
//   MemWrite   : store strobe, sampled at posedge clk
//   Read_data  : combinational load data returned by the slave
interface mmio_timer_uart_if;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;

  modport master (output Address, Write_data, MemRead, MemWrite, input Read_data);
  modport slave  (input Address, Write_data, MemRead, MemWrite, output Read_data);
endinterface

// File: rtl/mmio_timer_uart.sv
// Memory-mapped peripheral on the MEM-stage data bus: reloadable 32-bit timer
// with interrupt, LED / 7-segment / switch registers, free-running systick
// and an 8N1 UART transmitter.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high
//   bus      : slave side of the MEM-stage data bus
//   switch   : board switches (read at 0x10)
//   led      : LED register
//   digi     : 7-segment drive register
//   irq      : timer interrupt (irq_en & irq_status)
//   uart_txd : serial TX line, idle high
module mmio_timer_uart #(
  parameter int          BAUD_DIV = 434,
  parameter logic [23:0] BASE_HI  = 24'h400000
) (
  input  logic                clk,
  input  logic                reset,
  mmio_timer_uart_if.slave    bus,
  input  logic [7:0]          switch,
  output logic [7:0]          led,
  output logic [11:0]         digi,
  output logic                irq,
  output logic                uart_txd
);
  localparam int              BW        = $clog2(BAUD_DIV + 1);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);

  // word offsets (Address[7:2])
  localparam logic [5:0] OFF_TH   = 6'd0;
  localparam logic [5:0] OFF_TL   = 6'd1;
  localparam logic [5:0] OFF_TCON = 6'd2;
  localparam logic [5:0] OFF_LED  = 6'd3;
  localparam logic [5:0] OFF_SW   = 6'd4;
  localparam logic [5:0] OFF_DIGI = 6'd5;
  localparam logic [5:0] OFF_TXD  = 6'd6;
  localparam logic [5:0] OFF_UCON = 6'd7;
  localparam logic [5:0] OFF_TICK = 6'd8;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [31:0]   r_th, r_tl, r_systick;
  logic [2:0]    r_tcon;
  logic [7:0]    r_led, r_tx_byte;
  logic [11:0]   r_digi;
  logic          r_busy, r_done, r_txd;
  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [BW-1:0] r_baud_cnt;

  logic          w_sel, w_wr;
  logic [5:0]    w_off;
  logic          w_ovf, w_set_status, w_baud_end;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_sel    = (bus.Address[31:8] == BASE_HI);
  assign w_off    = bus.Address[7:2];
  assign w_wr     = bus.MemWrite && w_sel;
  assign w_unused = ^bus.Address[1:0];

  assign w_ovf        = r_tcon[0] && (r_tl == 32'hFFFF_FFFF);
  assign w_set_status = w_ovf && r_tcon[1];
  assign w_baud_end   = (r_baud_cnt == BAUD_LAST);

  assign led      = r_led;
  assign digi     = r_digi;
  assign irq      = r_tcon[1] & r_tcon[2];
  assign uart_txd = r_txd;

  // timer, GPIO registers and systick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_th      <= '0;
      r_tl      <= '0;
      r_tcon    <= '0;
      r_led     <= '0;
      r_digi    <= '0;
      r_systick <= '0;
    end else begin
      r_systick <= r_systick + 32'd1;
      if (w_wr && w_off == OFF_TH)   r_th   <= bus.Write_data;
      if (w_wr && w_off == OFF_LED)  r_led  <= bus.Write_data[7:0];
      if (w_wr && w_off == OFF_DIGI) r_digi <= bus.Write_data[11:0];

      // bus write beats the timer's own update
      if (w_wr && w_off == OFF_TL)   r_tl <= bus.Write_data;
      else if (r_tcon[0])            r_tl <= w_ovf ? r_th : r_tl + 32'd1;

      // an overflow landing on a TCON write still raises status
      if (w_wr && w_off == OFF_TCON)
        r_tcon <= {bus.Write_data[2] | w_set_status, bus.Write_data[1:0]};
      else if (w_set_status)
        r_tcon[2] <= 1'b1;
    end
  end

  // 8N1 transmitter; txd is registered so the line never glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_byte  <= '0;
      r_bit_cnt  <= '0;
      r_baud_cnt <= '0;
    end else begin
      // done-clear first so a same-cycle set from STOP overrides it
      if (w_wr && w_off == OFF_UCON && bus.Write_data[1]) r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_wr && w_off == OFF_TXD) begin
            r_tx_byte  <= bus.Write_data[7:0];
            r_busy     <= 1'b1;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_txd      <= 1'b0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            r_txd      <= r_tx_byte[0];
            r_state    <= S_DATA;
          end else r_baud_cnt <= r_baud_cnt + 1'b1;
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == 3'd7) begin
              r_txd   <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_txd     <= r_tx_byte[r_bit_cnt + 3'd1];
            end
          end else r_baud_cnt <= r_baud_cnt + 1'b1;
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_IDLE;
          end else r_baud_cnt <= r_baud_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // combinational, zero-extended load data
  always_comb begin
    w_rdata = '0;
    if (bus.MemRead && w_sel) begin
      case (w_off)
        OFF_TH:   w_rdata = r_th;
        OFF_TL:   w_rdata = r_tl;
        OFF_TCON: w_rdata = {29'd0, r_tcon};
        OFF_LED:  w_rdata = {24'd0, r_led};
        OFF_SW:   w_rdata = {24'd0, switch};
        OFF_DIGI: w_rdata = {20'd0, r_digi};
        OFF_TXD:  w_rdata = {24'd0, r_tx_byte};
        OFF_UCON: w_rdata = {30'd0, r_done, r_busy};
        OFF_TICK: w_rdata = r_systick;
        default:  w_rdata = '0;
      endcase
    end
  end
  assign bus.Read_data = w_rdata;
endmodule

// File: tb/tb_mmio_timer_uart.sv
module tb_mmio_timer_uart;
  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk, reset, irq, uart_txd;
  logic [7:0]  switch, led;
  logic [11:0] digi;
  mmio_timer_uart_if bus();

  mmio_timer_uart #(.BAUD_DIV(4), .BASE_HI(24'h400000)) dut (
    .clk(clk), .reset(reset), .bus(bus), .switch(switch),
    .led(led), .digi(digi), .irq(irq), .uart_txd(uart_txd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  logic        bit_q[$];
  logic [31:0] rd, ex;
  logic        eb;
  logic [31:0] cyc;

  // systick reference: cycles since reset release
  always @(posedge clk or posedge reset)
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;

  // both bus tasks start just after a negedge; a write spans one posedge
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.Address = a; bus.Write_data = d; bus.MemWrite = 1'b1;
    @(negedge clk);
    bus.MemWrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    bus.Address = a; bus.MemRead = 1'b1;
    #1 d = bus.Read_data;
    bus.MemRead = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; switch = 8'hA5;
    @(negedge clk);
    for (int o = 0; o < 12; o++) begin
      exp_q.push_back(o == 4 ? 32'h0000_00A5 : 32'h0);
      bus_rd(B + 32'(o * 4), rd);
      ex = exp_q.pop_front(); total++;
      if (rd !== ex) begin bad++; $display("FAIL rst_rd off=%0h got=%h exp=%h", o * 4, rd, ex); end
    end
    total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL rst_txd got=%b exp=1", uart_txd); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq); end
    @(negedge clk); reset = 1'b0;
    // MemRead low and wrong base both read zero
    bus.Address = B + 32'h10; bus.MemRead = 1'b0;
    #1 total++; if (bus.Read_data !== 32'h0) begin bad++; $display("FAIL noread got=%h exp=0", bus.Read_data); end
    exp_q.push_back(32'h0); bus_rd(32'h4000_0110, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL nosel_hi got=%h exp=%h", rd, ex); end
    exp_q.push_back(32'h0); bus_rd(32'h3FFF_FF10, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL nosel_lo got=%h exp=%h", rd, ex); end
  endtask

  task automatic test_regs;
    logic [31:0] ra [6];
    logic [31:0] re [6];
    @(negedge clk);
    bus_wr(B + 32'h0C, 32'h1234_56C3);
    bus_wr(B + 32'h14, 32'hFFFF_ABCD);
    bus_wr(B + 32'h10, 32'h0000_00FF);   // RO, ignored
    bus_wr(B + 32'h24, 32'hDEAD_BEEF);   // unmapped, ignored
    switch = 8'h3C;
    ra = '{B + 32'h0C, B + 32'h0F, B + 32'h14, B + 32'h10, B + 32'h24, B + 32'h16};
    re = '{32'hC3, 32'hC3, 32'hBCD, 32'h3C, 32'h0, 32'hBCD};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(re[i]);
      bus_rd(ra[i], rd);
      ex = exp_q.pop_front(); total++;
      if (rd !== ex) begin bad++; $display("FAIL regs[%0d] addr=%h got=%h exp=%h", i, ra[i], rd, ex); end
    end
    total++; if (led !== 8'hC3) begin bad++; $display("FAIL led_pin got=%h exp=c3", led); end
    total++; if (digi !== 12'hBCD) begin bad++; $display("FAIL digi_pin got=%h exp=bcd", digi); end
  endtask

  task automatic test_systick;
    for (int k = 0; k < 2; k++) begin
      repeat (7) @(negedge clk);
      exp_q.push_back(cyc);
      bus_rd(B + 32'h20, rd);
      ex = exp_q.pop_front(); total++;
      if (rd !== ex) begin bad++; $display("FAIL systick[%0d] got=%h exp=%h", k, rd, ex); end
    end
  endtask

  task automatic test_timer;
    @(negedge clk);
    bus_wr(B + 32'h00, 32'hFFFF_FFFC);
    bus_wr(B + 32'h04, 32'hFFFF_FFFE);
    bus_wr(B + 32'h08, 32'h3);              // enable takes effect from next edge
    exp_q.push_back(32'hFFFF_FFFE); bus_rd(B + 32'h04, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL tl_hold got=%h exp=%h", rd, ex); end
    @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFF); bus_rd(B + 32'h04, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL tl_inc got=%h exp=%h", rd, ex); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq); end
    @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFC); bus_rd(B + 32'h04, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL tl_reload got=%h exp=%h", rd, ex); end
    exp_q.push_back(32'h7); bus_rd(B + 32'h08, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL tcon_ovf got=%h exp=%h", rd, ex); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got=%b exp=1", irq); end
    bus_wr(B + 32'h08, 32'h3);              // clears status
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr got=%b exp=0", irq); end
    exp_q.push_back(32'hFFFF_FFFD); bus_rd(B + 32'h04, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL tl_after_clr got=%h exp=%h", rd, ex); end
    bus_wr(B + 32'h08, 32'h0);              // last increment on this edge, then hold
    @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFE); bus_rd(B + 32'h04, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL tl_disabled got=%h exp=%h", rd, ex); end
  endtask

  task automatic test_ovf_collision;
    @(negedge clk);
    bus_wr(B + 32'h00, 32'h0);
    bus_wr(B + 32'h04, 32'hFFFF_FFFD);
    bus_wr(B + 32'h08, 32'h3);
    @(negedge clk);                          // TL = FFFFFFFE
    @(negedge clk);                          // TL = FFFFFFFF
    bus_wr(B + 32'h08, 32'h3);              // lands on the overflow edge
    exp_q.push_back(32'h7); bus_rd(B + 32'h08, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL tcon_coll got=%h exp=%h", rd, ex); end
    exp_q.push_back(32'h0); bus_rd(B + 32'h04, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL tl_coll got=%h exp=%h", rd, ex); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_coll got=%b exp=1", irq); end
    bus_wr(B + 32'h08, 32'h0);
  endtask

  task automatic test_tl_collision;
    bus_wr(B + 32'h04, 32'h100);
    bus_wr(B + 32'h08, 32'h1);
    @(negedge clk);                          // TL = 0x101
    bus_wr(B + 32'h04, 32'h5);              // write beats increment
    exp_q.push_back(32'h5); bus_rd(B + 32'h04, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL tl_wr_wins got=%h exp=%h", rd, ex); end
    @(negedge clk);
    exp_q.push_back(32'h6); bus_rd(B + 32'h04, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL tl_wr_next got=%h exp=%h", rd, ex); end
    bus_wr(B + 32'h08, 32'h0);
  endtask

  // sends one frame and checks every cycle of it; optionally a second TXD
  // write at cycle 'mid' and a done-clear on the edge that sets done
  task automatic run_frame(input logic [7:0] b, input int mid, input logic [7:0] mid_b, input bit clr_end);
    bus_wr(B + 32'h18, {24'h0, b});
    bit_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) bit_q.push_back(b[k]);
    bit_q.push_back(1'b1);
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) eb = bit_q.pop_front();
      total++; if (uart_txd !== eb) begin bad++; $display("FAIL txd byte=%h cyc=%0d got=%b exp=%b", b, i, uart_txd, eb); end
      bus_rd(B + 32'h1C, rd);
      total++; if (rd[0] !== 1'b1) begin bad++; $display("FAIL busy byte=%h cyc=%0d got=%b exp=1", b, i, rd[0]); end
      if (i == mid) begin bus.Address = B + 32'h18; bus.Write_data = {24'h0, mid_b}; bus.MemWrite = 1'b1; end
      if (clr_end && i == 39) begin bus.Address = B + 32'h1C; bus.Write_data = 32'h2; bus.MemWrite = 1'b1; end
      @(negedge clk);
      bus.MemWrite = 1'b0;
    end
    total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL txd_idle got=%b exp=1", uart_txd); end
    exp_q.push_back(32'h2); bus_rd(B + 32'h1C, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL ucon_done byte=%h got=%h exp=%h", b, rd, ex); end
  endtask

  task automatic test_uart;
    @(negedge clk);
    run_frame(8'h53, 10, 8'hFF, 1'b0);
    exp_q.push_back(32'h53); bus_rd(B + 32'h18, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL txbyte_kept got=%h exp=%h", rd, ex); end
    bus_wr(B + 32'h1C, 32'h2);
    exp_q.push_back(32'h0); bus_rd(B + 32'h1C, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL done_clr got=%h exp=%h", rd, ex); end
  endtask

  task automatic test_reset_midframe;
    @(negedge clk);
    bus_wr(B + 32'h18, 32'h3C);
    repeat (11) @(negedge clk);              // DATA, bit1 of 0x3C = 0
    total++; if (uart_txd !== 1'b0) begin bad++; $display("FAIL pre_rst_txd got=%b exp=0", uart_txd); end
    reset = 1'b1;
    #1 total++; if (uart_txd !== 1'b1) begin bad++; $display("FAIL midrst_txd got=%b exp=1", uart_txd); end
    exp_q.push_back(32'h0); bus_rd(B + 32'h1C, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL midrst_ucon got=%h exp=%h", rd, ex); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    run_frame(8'hC6, -1, 8'h00, 1'b1);      // clear collides with set: set wins
    exp_q.push_back(32'hC6); bus_rd(B + 32'h18, rd);
    ex = exp_q.pop_front(); total++; if (rd !== ex) begin bad++; $display("FAIL txbyte_new got=%h exp=%h", rd, ex); end
  endtask

  initial begin
    reset = 1'b1; switch = '0;
    bus.Address = '0; bus.Write_data = '0; bus.MemRead = 1'b0; bus.MemWrite = 1'b0;
    test_reset;
    test_regs;
    test_systick;
    test_timer;
    test_ovf_collision;
    test_tl_collision;
    test_uart;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmio_timer_uart.md
Name: mmio_timer_uart

Overview:
- Memory-mapped peripheral slave on the pipeline's MEM-stage data bus, in parallel with the data RAM.
- Uses the same Address / Write_data / MemRead / MemWrite / Read_data protocol as the RAM. The MEM-stage read mux selects it when Address[31:8] == 24'h400000.
- Provides a reloadable 32-bit timer with interrupt, LED / 7-segment / switch registers, a free-running systick, and an 8N1 UART transmitter.

Parameters:
- BAUD_DIV, 434, clk cycles per UART bit (50 MHz / 115200).
- BASE_HI, 24'h400000, Address[31:8] value that selects this block.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Address  in  32  byte address from the MEM stage.
- Write_data  in  32  store data.
- MemRead  in  1  load strobe.
- MemWrite  in  1  store strobe, sampled at posedge clk.
- Read_data  out  32  combinational load data.
- switch  in  8  board switches.
- led  out  8  LED register.
- digi  out  12  7-segment drive register.
- irq  out  1  timer interrupt request.
- uart_txd  out  1  serial TX line, idle high.

Behaviour:
- Select: sel = (Address[31:8] == BASE_HI). Word offset = Address[7:2]; Address[1:0] ignored.
- Register map (byte offset):
  - 0x00 TH, reload value, R/W.
  - 0x04 TL, counter, R/W.
  - 0x08 TCON[2:0], R/W: bit0 enable, bit1 irq_en, bit2 irq_status.
  - 0x0C led[7:0], R/W.
  - 0x10 switch[7:0], RO.
  - 0x14 digi[11:0], R/W.
  - 0x18 UART_TXD[7:0]: a write starts transmission; reads return the last latched byte.
  - 0x1C UART_CON: bit0 busy (RO), bit1 done (sticky; writing 1 to bit1 clears it).
  - 0x20 SYSTICK, RO.
- Reads:
  - Read_data is purely combinational and zero-extended.
  - Read_data = 0 when MemRead = 0, when sel = 0, or for an unmapped offset.
- Writes:
  - Occur at posedge clk when MemWrite && sel.
  - Writes to unmapped or RO offsets are ignored.
- Reset (async) values: TH = 0, TL = 0, TCON = 0, led = 0, digi = 0, SYSTICK = 0, tx byte = 0, busy = 0, done = 0, uart_txd = 1, irq = 0, UART FSM in IDLE.
- SYSTICK: increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
- Timer, when TCON[0] = 1, each cycle:
  - If TL == 32'hFFFFFFFF: TL <= TH, and if TCON[1] is set, TCON[2] <= 1.
  - Otherwise TL <= TL + 1.
  - When TCON[0] = 0, TL holds.
- irq = TCON[1] & TCON[2]; combinational from registers.
- Timer collisions:
  - A bus write to TL in the same cycle as an increment or reload: the write wins.
  - A bus write to TCON in the same cycle as an overflow that would set status: TCON[1:0] take the written value; TCON[2] = written bit2 OR overflow-set, so no event is lost.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: uart_txd = 1.
  - A write to 0x18 in IDLE latches Write_data[7:0], sets busy = 1, clears the bit counter and baud counter, and moves to START next cycle. uart_txd = 0 from that cycle.
  - START: holds for BAUD_DIV cycles, then DATA.
  - DATA: sends bits 0..7 LSB first, each for BAUD_DIV cycles, then STOP.
  - STOP: uart_txd = 1 for BAUD_DIV cycles, then IDLE with busy = 0 and done = 1.
  - Frame length is exactly 10*BAUD_DIV cycles from the first low cycle to the return to IDLE.
  - A write to 0x18 while busy is ignored: the latched byte is unchanged.
  - A done-clear write in the same cycle that the FSM sets done: the set wins.
- Reset asserted mid-frame: uart_txd returns high immediately (async), FSM goes to IDLE, and the frame is abandoned.

Test Plan:
- Reset, then read every offset with MemRead = 1 and switch = 8'hA5 → all read 0 except 0x10, which reads 0x000000A5. uart_txd = 1, irq = 0.
- Write TH = 0xFFFFFFFC, TL = 0xFFFFFFFE, TCON = 3 → TL reads 0xFFFFFFFF, then 0xFFFFFFFC; TCON reads 7 and irq = 1 two cycles after enable. Writing TCON = 3 clears irq next cycle.
- Write TCON = 3 in the exact overflow cycle → TCON reads 7 afterwards (status preserved).
- BAUD_DIV = 4, write 0x18 = 0x53 → uart_txd sequence per 4-cycle bit is 0,1,1,0,0,1,0,1,0,1; busy = 1 for 40 cycles, then done = 1.
- A second write of 0x18 = 0xFF mid-frame → waveform unchanged and reads of 0x18 still return 0x53. Writing 0x1C = 2 clears done.
- Assert reset mid-frame during DATA → uart_txd = 1 and busy = 0 immediately. A new 0x18 write after reset transmits a correct frame.
